mc_controller: RTL and testbench
================================

// Module: mc_controller
// PURPOSE
//  Multicycle MIPS control FSM, directly upstream of the 32-bit multicycle datapath.
//  Consumes op/funct/zero from the datapath and drives every datapath control input each cycle.
//  Also drives the external memory write strobe.
//  Supported: R-type add/sub/and/or/slt, lw, lb, lbu, sw, beq, bne, addi, andi, ori, j.
// PARAMETERS
//  none (opcode/funct encodings are fixed MIPS-I values listed below)
// PORTS
//  clk         in   1  system clock, all state changes on rising edge
//  reset       in   1  asynchronous, active-low reset
//  op          in   6  instr[31:26] from datapath instruction register
//  funct       in   6  instr[5:0]
//  zero        in   1  ALU zero flag (combinational, current cycle)
//  pcen        out  1  PC register enable
//  irwrite     out  1  instruction register enable
//  regwrite    out  1  register file write enable
//  memwrite    out  1  data memory write strobe
//  iord        out  1  0: address=pc, 1: address=aluout
//  memtoreg    out  1  0: wd=aluout, 1: wd=data reg
//  regdst      out  1  0: rt, 1: rd
//  alusrca     out  1  0: pc, 1: rs reg
//  alusrcb     out  3  000 rt reg, 001 const 4, 010 signimm, 011 signimm<<2, 100 zeroimm
//  pcsrc       out  2  00 aluresult, 01 aluout, 10 jump target
//  alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
//  ltype       out  2  00 word, 01 byte zero-ext, 10 byte sign-ext
//  illegal     out  1  1-cycle pulse in DECODE on unsupported op or R-type funct
//  state       out  4  current state encoding (debug)
// BEHAVIOUR
//  Opcodes: R 000000, lw 100011, lb 100000, lbu 100100, sw 101011, beq 000100, bne 000101,
//   addi 001000, andi 001100, ori 001101, j 000010.
//  Functs: add 100000, sub 100010, and 100100, or 100101, slt 101010.
//  Moore outputs decoded from state (+ op/funct where noted); default per cycle: all 0,
//   alucontrol=010. pcen = pcwrite | (beqst & zero) | (bnest & ~zero), combinational.
//  States/outputs -> next:
//   FETCH   iord=0 irwrite=1 alusrca=0 alusrcb=001 add pcsrc=00 pcwrite=1 -> DECODE
//   DECODE  alusrca=0 alusrcb=011 add (branch target to aluout) -> by op; bad op/funct -> FETCH + illegal
//   MEMADR  alusrca=1 alusrcb=010 add -> sw: MEMWR, lw/lb/lbu: MEMRD
//   MEMRD   iord=1 ltype=(lw 00, lbu 01, lb 10) -> MEMWB
//   MEMWB   regdst=0 memtoreg=1 regwrite=1 -> FETCH
//   MEMWR   iord=1 memwrite=1 -> FETCH
//   RTEX    alusrca=1 alusrcb=000 alucontrol from funct -> RTWB
//   RTWB    regdst=1 memtoreg=0 regwrite=1 -> FETCH
//   BEQEX   alusrca=1 alusrcb=000 sub pcsrc=01 beqst -> FETCH
//   BNEEX   alusrca=1 alusrcb=000 sub pcsrc=01 bnest -> FETCH
//   IEX     alusrca=1; addi: 010/add, andi: 100/and, ori: 100/or -> IWB
//   IWB     regdst=0 memtoreg=0 regwrite=1 -> FETCH
//   JEX     pcsrc=10 pcwrite=1 -> FETCH
//  Cycles/instr: lw/lb/lbu 5, sw 4, R 4, imm 4, beq/bne/j 3, illegal 2.
//  Reset (reset=0): state=FETCH immediately; pcen, irwrite, regwrite, memwrite forced 0
//   while asserted; other outputs show FETCH values; illegal=0. First fetch on first
//   rising edge after release. Reset mid-instruction abandons it; no partial writes.
//  Unused state codes -> FETCH next cycle, all enables 0 in that cycle.
//  op/funct may change only after FETCH; controller samples them in DECODE onward.
// TESTING
//  reset low mid-RTEX, release -> state=FETCH, no regwrite; next edge irwrite=1 pcen=1.
//  lw (op 100011) -> FETCH,DECODE,MEMADR,MEMRD(iord=1,ltype=00),MEMWB(regwrite=1,memtoreg=1).
//  lb then lbu -> ltype=10 then 01 in MEMRD; sw -> memwrite=1 exactly one cycle, 4 cycles total.
//  beq zero=1 -> pcen=1 pcsrc=01 in BEQEX; zero=0 -> pcen=0; bne inverse.
//  R funct 101010 -> alucontrol=111 RTEX, regdst=1 RTWB; funct 000111 -> illegal pulse, FETCH.
//  j (000010) -> JEX pcsrc=10 pcen=1, back to FETCH after 3 cycles.

Source files
------------

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM: walks each instruction through its micro-steps and
// drives every datapath control input plus the external memory write strobe.
module mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       irwrite,
    output logic       regwrite,
    output logic       memwrite,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [2:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic [1:0] ltype,
    output logic       illegal,
    output logic [3:0] state
);

    localparam int unsigned OP_W    = 6;
    localparam int unsigned STATE_W = 4;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_LB    = 6'b100000;
    localparam logic [OP_W-1:0] OP_LBU   = 6'b100100;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [OP_W-1:0] FN_ADD = 6'b100000;
    localparam logic [OP_W-1:0] FN_SUB = 6'b100010;
    localparam logic [OP_W-1:0] FN_AND = 6'b100100;
    localparam logic [OP_W-1:0] FN_OR  = 6'b100101;
    localparam logic [OP_W-1:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [2:0] SRCB_RT    = 3'b000;
    localparam logic [2:0] SRCB_FOUR  = 3'b001;
    localparam logic [2:0] SRCB_SIMM  = 3'b010;
    localparam logic [2:0] SRCB_BOFF  = 3'b011;
    localparam logic [2:0] SRCB_ZIMM  = 3'b100;

    localparam logic [1:0] PC_ALURES = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] LT_WORD = 2'b00;
    localparam logic [1:0] LT_BU   = 2'b01;
    localparam logic [1:0] LT_BS   = 2'b10;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEX   = 4'd6,
        S_RTWB   = 4'd7,
        S_BEQEX  = 4'd8,
        S_BNEEX  = 4'd9,
        S_IEX    = 4'd10,
        S_IWB    = 4'd11,
        S_JEX    = 4'd12
    } state_e;

    state_e state_q;
    state_e state_d;

    logic       op_ok;
    logic       funct_ok;
    logic       instr_ok;
    logic [2:0] funct_alu;
    logic       pcwrite;
    logic       beqst;
    logic       bnest;

    // Opcode / funct legality and R-type ALU operation.
    always_comb begin
        op_ok     = 1'b1;
        funct_ok  = 1'b1;
        funct_alu = ALU_ADD;
        case (op)
            OP_RTYPE, OP_LW, OP_LB, OP_LBU, OP_SW, OP_BEQ,
            OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_J: op_ok = 1'b1;
            default:                                op_ok = 1'b0;
        endcase
        case (funct)
            FN_ADD:  funct_alu = ALU_ADD;
            FN_SUB:  funct_alu = ALU_SUB;
            FN_AND:  funct_alu = ALU_AND;
            FN_OR:   funct_alu = ALU_OR;
            FN_SLT:  funct_alu = ALU_SLT;
            default: funct_ok  = 1'b0;
        endcase
        instr_ok = op_ok && ((op != OP_RTYPE) || funct_ok);
    end

    // State register; reset parks the FSM in FETCH at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (!instr_ok) begin
                    state_d = S_FETCH;
                end else begin
                    case (op)
                        OP_RTYPE:                   state_d = S_RTEX;
                        OP_LW, OP_LB, OP_LBU, OP_SW: state_d = S_MEMADR;
                        OP_BEQ:                     state_d = S_BEQEX;
                        OP_BNE:                     state_d = S_BNEEX;
                        OP_ADDI, OP_ANDI, OP_ORI:   state_d = S_IEX;
                        OP_J:                       state_d = S_JEX;
                        default:                    state_d = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = S_FETCH;
            S_RTEX:   state_d = S_RTWB;
            S_RTWB:   state_d = S_FETCH;
            S_BEQEX:  state_d = S_FETCH;
            S_BNEEX:  state_d = S_FETCH;
            S_IEX:    state_d = S_IWB;
            S_IWB:    state_d = S_FETCH;
            S_JEX:    state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // Output decode; enables are masked while reset is held.
    always_comb begin
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        memwrite   = 1'b0;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = SRCB_RT;
        pcsrc      = PC_ALURES;
        alucontrol = ALU_ADD;
        ltype      = LT_WORD;
        illegal    = 1'b0;
        pcwrite    = 1'b0;
        beqst      = 1'b0;
        bnest      = 1'b0;
        case (state_q)
            S_FETCH: begin
                irwrite = 1'b1;
                alusrcb = SRCB_FOUR;
                pcwrite = 1'b1;
            end
            S_DECODE: begin
                alusrcb = SRCB_BOFF;
                illegal = ~instr_ok;
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_SIMM;
            end
            S_MEMRD: begin
                iord = 1'b1;
                case (op)
                    OP_LBU:  ltype = LT_BU;
                    OP_LB:   ltype = LT_BS;
                    default: ltype = LT_WORD;
                endcase
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_RTEX: begin
                alusrca    = 1'b1;
                alusrcb    = SRCB_RT;
                alucontrol = funct_alu;
            end
            S_RTWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BEQEX, S_BNEEX: begin
                alusrca    = 1'b1;
                alusrcb    = SRCB_RT;
                alucontrol = ALU_SUB;
                pcsrc      = PC_ALUOUT;
                beqst      = (state_q == S_BEQEX);
                bnest      = (state_q == S_BNEEX);
            end
            S_IEX: begin
                alusrca = 1'b1;
                case (op)
                    OP_ANDI: begin
                        alusrcb    = SRCB_ZIMM;
                        alucontrol = ALU_AND;
                    end
                    OP_ORI: begin
                        alusrcb    = SRCB_ZIMM;
                        alucontrol = ALU_OR;
                    end
                    default: begin
                        alusrcb    = SRCB_SIMM;
                        alucontrol = ALU_ADD;
                    end
                endcase
            end
            S_IWB: begin
                regwrite = 1'b1;
            end
            S_JEX: begin
                pcsrc   = PC_JUMP;
                pcwrite = 1'b1;
            end
            default: begin
                alucontrol = ALU_ADD;
            end
        endcase
        pcen = pcwrite | (beqst & zero) | (bnest & ~zero);
        if (!reset) begin
            pcen     = 1'b0;
            irwrite  = 1'b0;
            regwrite = 1'b0;
            memwrite = 1'b0;
            illegal  = 1'b0;
        end
    end

    assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: random and directed instruction streams compared cycle by
// cycle against a per-instruction-class model of the control bundle.
module tb_mc_controller;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen, irwrite, regwrite, memwrite, iord, memtoreg, regdst, alusrca;
    logic [2:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic [1:0] ltype;
    logic       illegal;
    logic [3:0] state;

    int tests_run;
    int tests_failed;

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .pcen       (pcen),
        .irwrite    (irwrite),
        .regwrite   (regwrite),
        .memwrite   (memwrite),
        .iord       (iord),
        .memtoreg   (memtoreg),
        .regdst     (regdst),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .ltype      (ltype),
        .illegal    (illegal),
        .state      (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bundle: {pcen,irwrite,regwrite,memwrite,iord,memtoreg,regdst,alusrca,alusrcb,pcsrc,alucontrol,ltype,illegal}
    function automatic logic [18:0] pack(input logic pe, irw, rw, mw, io, m2r, rd, sa,
                                         input logic [2:0] sb, input logic [1:0] ps,
                                         input logic [2:0] ac, input logic [1:0] lt,
                                         input logic il);
        return {pe, irw, rw, mw, io, m2r, rd, sa, sb, ps, ac, lt, il};
    endfunction

    function automatic logic [18:0] dut_bundle();
        return {pcen, irwrite, regwrite, memwrite, iord, memtoreg, regdst, alusrca,
                alusrcb, pcsrc, alucontrol, ltype, illegal};
    endfunction

    // Instruction classes: 0 illegal, 1 load, 2 store, 3 R, 4 beq, 5 bne, 6 imm, 7 jump
    function automatic int classify(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'b000000: begin
                if (f == 6'b100000 || f == 6'b100010 || f == 6'b100100 ||
                    f == 6'b100101 || f == 6'b101010) return 3;
                return 0;
            end
            6'b100011, 6'b100000, 6'b100100: return 1;
            6'b101011: return 2;
            6'b000100: return 4;
            6'b000101: return 5;
            6'b001000, 6'b001100, 6'b001101: return 6;
            6'b000010: return 7;
            default: return 0;
        endcase
    endfunction

    function automatic int n_cycles(input logic [5:0] o, input logic [5:0] f);
        case (classify(o, f))
            0: return 2;
            1: return 5;
            2, 3, 6: return 4;
            default: return 3;
        endcase
    endfunction

    function automatic logic [2:0] r_alu(input logic [5:0] f);
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Expected control bundle for cycle `step` of an instruction.
    function automatic logic [18:0] exp_ctl(input logic [5:0] o, input logic [5:0] f,
                                            input logic z, input int step);
        int c;
        c = classify(o, f);
        if (step == 0) return pack(1, 1, 0, 0, 0, 0, 0, 0, 3'b001, 2'b00, 3'b010, 2'b00, 0);
        if (step == 1) return pack(0, 0, 0, 0, 0, 0, 0, 0, 3'b011, 2'b00, 3'b010, 2'b00, c == 0);
        case (c)
            1: begin
                if (step == 2) return pack(0, 0, 0, 0, 0, 0, 0, 1, 3'b010, 2'b00, 3'b010, 2'b00, 0);
                if (step == 3) return pack(0, 0, 0, 0, 1, 0, 0, 0, 3'b000, 2'b00, 3'b010,
                                           (o == 6'b100100) ? 2'b01 : (o == 6'b100000) ? 2'b10 : 2'b00, 0);
                return pack(0, 0, 1, 0, 0, 1, 0, 0, 3'b000, 2'b00, 3'b010, 2'b00, 0);
            end
            2: begin
                if (step == 2) return pack(0, 0, 0, 0, 0, 0, 0, 1, 3'b010, 2'b00, 3'b010, 2'b00, 0);
                return pack(0, 0, 0, 1, 1, 0, 0, 0, 3'b000, 2'b00, 3'b010, 2'b00, 0);
            end
            3: begin
                if (step == 2) return pack(0, 0, 0, 0, 0, 0, 0, 1, 3'b000, 2'b00, r_alu(f), 2'b00, 0);
                return pack(0, 0, 1, 0, 0, 0, 1, 0, 3'b000, 2'b00, 3'b010, 2'b00, 0);
            end
            4: return pack(z, 0, 0, 0, 0, 0, 0, 1, 3'b000, 2'b01, 3'b110, 2'b00, 0);
            5: return pack(~z, 0, 0, 0, 0, 0, 0, 1, 3'b000, 2'b01, 3'b110, 2'b00, 0);
            6: begin
                if (step == 2) begin
                    if (o == 6'b001100) return pack(0, 0, 0, 0, 0, 0, 0, 1, 3'b100, 2'b00, 3'b000, 2'b00, 0);
                    if (o == 6'b001101) return pack(0, 0, 0, 0, 0, 0, 0, 1, 3'b100, 2'b00, 3'b001, 2'b00, 0);
                    return pack(0, 0, 0, 0, 0, 0, 0, 1, 3'b010, 2'b00, 3'b010, 2'b00, 0);
                end
                return pack(0, 0, 1, 0, 0, 0, 0, 0, 3'b000, 2'b00, 3'b010, 2'b00, 0);
            end
            default: return pack(1, 0, 0, 0, 0, 0, 0, 0, 3'b000, 2'b10, 3'b010, 2'b00, 0);
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Runs cycles first..last of an instruction; zmode 0/1 fixes zero, 2 randomises it per cycle.
    task automatic run_steps(input logic [5:0] o, input logic [5:0] f, input int zmode,
                             input int first, input int last);
        op    = o;
        funct = f;
        for (int s = first; s <= last; s++) begin
            zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            #1;
            check_eq($sformatf("op%b_fn%b_s%0d", o, f, s), 32'(dut_bundle()),
                     32'(exp_ctl(o, f, zero, s)));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zmode);
        run_steps(o, f, zmode, 0, n_cycles(o, f) - 1);
    endtask

    logic [5:0] op_tbl [11];
    logic [5:0] fn_tbl [5];
    logic [18:0] rst_vec;
    logic [18:0] fetch_vec;
    logic [5:0] ro, rf;

    initial begin
        op_tbl = '{6'b000000, 6'b100011, 6'b100000, 6'b100100, 6'b101011, 6'b000100,
                   6'b000101, 6'b001000, 6'b001100, 6'b001101, 6'b000010};
        fn_tbl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        rst_vec   = pack(0, 0, 0, 0, 0, 0, 0, 0, 3'b001, 2'b00, 3'b010, 2'b00, 0);
        fetch_vec = pack(1, 1, 0, 0, 0, 0, 0, 0, 3'b001, 2'b00, 3'b010, 2'b00, 0);
        tests_run    = 0;
        tests_failed = 0;
        reset = 1'b0;
        op    = 6'b000000;
        funct = 6'b101010;
        zero  = 1'b0;

        #3;
        check_eq("reset_hold0", 32'(dut_bundle()), 32'(rst_vec));
        @(posedge clk);
        #1;
        check_eq("reset_hold1", 32'(dut_bundle()), 32'(rst_vec));
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("release_fetch", 32'(dut_bundle()), 32'(fetch_vec));

        // Directed sequence from the instruction list.
        run_instr(6'b100011, 6'b000000, 2);
        run_instr(6'b100000, 6'b000000, 2);
        run_instr(6'b100100, 6'b000000, 2);
        run_instr(6'b101011, 6'b000000, 2);
        run_instr(6'b000100, 6'b000000, 1);
        run_instr(6'b000100, 6'b000000, 0);
        run_instr(6'b000101, 6'b000000, 1);
        run_instr(6'b000101, 6'b000000, 0);
        run_instr(6'b000000, 6'b101010, 2);
        run_instr(6'b000000, 6'b000111, 2);
        run_instr(6'b000010, 6'b000000, 2);
        run_instr(6'b001000, 6'b000000, 2);
        run_instr(6'b001100, 6'b000000, 2);
        run_instr(6'b001101, 6'b000000, 2);
        run_instr(6'b111111, 6'b000000, 2);

        // Reset asserted in the middle of an R-type execute cycle.
        run_steps(6'b000000, 6'b100010, 2, 0, 1);
        #1;
        check_eq("rtex_before_rst", 32'(dut_bundle()), 32'(exp_ctl(6'b000000, 6'b100010, 1'b0, 2)));
        #1;
        reset = 1'b0;
        #1;
        check_eq("rst_mid_rtex", 32'(dut_bundle()), 32'(rst_vec));
        @(posedge clk);
        #1;
        check_eq("rst_no_rtwb", 32'(dut_bundle()), 32'(rst_vec));
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("rst_release_fetch", 32'(dut_bundle()), 32'(fetch_vec));
        run_instr(6'b000000, 6'b100101, 2);

        // Random instruction stream.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) ro = 6'($urandom);
            else ro = op_tbl[$urandom_range(0, 10)];
            if ($urandom_range(0, 3) == 0) rf = 6'($urandom);
            else rf = fn_tbl[$urandom_range(0, 4)];
            run_instr(ro, rf, 2);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
